// File: rtl/hazard_forward_unit_pkg.sv
// Shared definitions for the hazard/forwarding control slice: operand-mux
// select encodings and default widths.
package hazard_forward_unit_pkg;

    localparam int unsigned DEF_REG_ADDR_W = 5;
    localparam int unsigned DEF_CNT_W      = 16;

    // Operand forwarding mux select; 2'b11 is never produced.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/hazard_forward_unit_fwd_sel.sv
// Priority comparator for one EX-stage source operand: the EX/MEM result beats
// the MEM/WB result, and x0 never forwards.
module hazard_forward_unit_fwd_sel
    import hazard_forward_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  ex_valid_i,
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic                  mem_valid_i,
    input  logic                  mem_regwrite_i,
    input  logic [REG_ADDR_W-1:0] mem_rd_i,
    input  logic                  wb_valid_i,
    input  logic                  wb_regwrite_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    output fwd_sel_e              sel_o
);

    logic mem_hit;
    logic wb_hit;

    always_comb begin
        mem_hit = mem_valid_i & mem_regwrite_i & (mem_rd_i != '0) & (mem_rd_i == rs_i);
        wb_hit  = wb_valid_i & wb_regwrite_i & (wb_rd_i != '0) & (wb_rd_i == rs_i);
        sel_o   = FWD_RF;
        if (ex_valid_i) begin
            if (mem_hit) begin
                sel_o = FWD_MEM;
            end else if (wb_hit) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding control: shadow ID/EX, EX/MEM, MEM/WB tags, operand
// forwarding selects, one-cycle load-use stall and a saturating stall counter.
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_regwrite_i,
    input  logic                  id_memread_i,
    input  logic                  flush_i,
    output logic [1:0]            fwd_a_o,
    output logic [1:0]            fwd_b_o,
    output logic                  stall_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  memread;
    } ex_stage_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
        logic                  memread;
    } mem_stage_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  regwrite;
    } wb_stage_t;

    ex_stage_t  ex_q,  ex_d;
    mem_stage_t mem_q, mem_d;
    wb_stage_t  wb_q,  wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic     stall;
    logic     load_rd_hit;
    fwd_sel_e fwd_a;
    fwd_sel_e fwd_b;

    // rs2 is compared even when the ID instruction does not read it.
    always_comb begin
        load_rd_hit = (ex_q.rd == id_rs1_i) | (ex_q.rd == id_rs2_i);
        stall = id_valid_i & ~flush_i & ex_q.valid & ex_q.memread
              & (ex_q.rd != '0) & load_rd_hit;
    end

    always_comb begin
        ex_d.valid    = id_valid_i & ~stall & ~flush_i;
        ex_d.rs1      = id_rs1_i;
        ex_d.rs2      = id_rs2_i;
        ex_d.rd       = id_rd_i;
        ex_d.regwrite = id_regwrite_i;
        ex_d.memread  = id_memread_i;

        mem_d.valid    = ex_q.valid;
        mem_d.rd       = ex_q.rd;
        mem_d.regwrite = ex_q.regwrite;
        mem_d.memread  = ex_q.memread;

        wb_d.valid    = mem_q.valid;
        wb_d.rd       = mem_q.rd;
        wb_d.regwrite = mem_q.regwrite;

        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    hazard_forward_unit_fwd_sel #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_a (
        .ex_valid_i     (ex_q.valid),
        .rs_i           (ex_q.rs1),
        .mem_valid_i    (mem_q.valid),
        .mem_regwrite_i (mem_q.regwrite),
        .mem_rd_i       (mem_q.rd),
        .wb_valid_i     (wb_q.valid),
        .wb_regwrite_i  (wb_q.regwrite),
        .wb_rd_i        (wb_q.rd),
        .sel_o          (fwd_a)
    );

    hazard_forward_unit_fwd_sel #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd_b (
        .ex_valid_i     (ex_q.valid),
        .rs_i           (ex_q.rs2),
        .mem_valid_i    (mem_q.valid),
        .mem_regwrite_i (mem_q.regwrite),
        .mem_rd_i       (mem_q.rd),
        .wb_valid_i     (wb_q.valid),
        .wb_regwrite_i  (wb_q.regwrite),
        .wb_rd_i        (wb_q.rd),
        .sel_o          (fwd_b)
    );

    // A load in MEM feeding the EX instruction is impossible thanks to the stall.
    always_comb begin
        if (rst_i && ex_q.valid) begin
            assert (!(mem_q.valid && mem_q.memread && mem_q.regwrite && (mem_q.rd != '0)
                      && ((mem_q.rd == ex_q.rs1) || (mem_q.rd == ex_q.rs2))));
        end
    end

    assign fwd_a_o     = fwd_a;
    assign fwd_b_o     = fwd_b;
    assign stall_o     = stall;
    assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed table-driven bench for hazard_forward_unit, plus a CNT_W=2 copy
// sharing the same stimulus to exercise counter saturation.
module tb_hazard_forward_unit;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_regwrite, id_memread, flush;
    logic [1:0] fwd_a, fwd_b, sat_fwd_a, sat_fwd_b;
    logic       stall, sat_stall;
    logic [15:0] stall_cnt;
    logic [1:0]  sat_cnt;

    int checks = 0;
    int errors = 0;

    hazard_forward_unit u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .id_valid_i    (id_valid),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_rd_i       (id_rd),
        .id_regwrite_i (id_regwrite),
        .id_memread_i  (id_memread),
        .flush_i       (flush),
        .fwd_a_o       (fwd_a),
        .fwd_b_o       (fwd_b),
        .stall_o       (stall),
        .stall_cnt_o   (stall_cnt)
    );

    hazard_forward_unit #(
        .CNT_W (2)
    ) u_sat (
        .clk_i         (clk),
        .rst_i         (rst),
        .id_valid_i    (id_valid),
        .id_rs1_i      (id_rs1),
        .id_rs2_i      (id_rs2),
        .id_rd_i       (id_rd),
        .id_regwrite_i (id_regwrite),
        .id_memread_i  (id_memread),
        .flush_i       (flush),
        .fwd_a_o       (sat_fwd_a),
        .fwd_b_o       (sat_fwd_b),
        .stall_o       (sat_stall),
        .stall_cnt_o   (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rs1, rs2, rd;
        logic       rw, mr, fl;
        logic [1:0] a, b;
        logic       st;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[35];

    function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic rw, input logic mr,
                                input logic fl, input logic [1:0] a, input logic [1:0] b,
                                input logic st, input logic [15:0] cnt);
        vec_t r;
        r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.rw = rw; r.mr = mr; r.fl = fl;
        r.a = a; r.b = b; r.st = st; r.cnt = cnt;
        return r;
    endfunction

    function automatic vec_t nop(input logic [1:0] a, input logic [1:0] b, input logic [15:0] cnt);
        return mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, a, b, 1'b0, cnt);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic rw, input logic mr, input logic fl);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_regwrite = rw; id_memread = mr; flush = fl;
    endtask

    initial begin
        // EX/MEM forward, x0 destination
        vecs[0]  = mk(1, 1, 2, 5, 1, 0, 0, 2'd0, 2'd0, 0, 0);
        vecs[1]  = mk(1, 5, 7, 6, 1, 0, 0, 2'd0, 2'd0, 0, 0);
        vecs[2]  = nop(2'd2, 2'd0, 0);
        vecs[3]  = nop(2'd0, 2'd0, 0);
        vecs[4]  = mk(1, 1, 2, 0, 1, 0, 0, 2'd0, 2'd0, 0, 0);
        vecs[5]  = mk(1, 0, 7, 6, 1, 0, 0, 2'd0, 2'd0, 0, 0);
        vecs[6]  = nop(2'd0, 2'd0, 0);
        // double hazard: MEM beats WB; then one-instruction gap -> WB
        vecs[7]  = mk(1, 1, 2, 5, 1, 0, 0, 2'd0, 2'd0, 0, 0);
        vecs[8]  = mk(1, 3, 4, 5, 1, 0, 0, 2'd0, 2'd0, 0, 0);
        vecs[9]  = mk(1, 1, 5, 10, 1, 0, 0, 2'd0, 2'd0, 0, 0);
        vecs[10] = nop(2'd0, 2'd2, 0);
        vecs[11] = mk(1, 1, 2, 11, 1, 0, 0, 2'd0, 2'd0, 0, 0);
        vecs[12] = nop(2'd0, 2'd0, 0);
        vecs[13] = mk(1, 3, 11, 12, 1, 0, 0, 2'd0, 2'd0, 0, 0);
        vecs[14] = nop(2'd0, 2'd1, 0);
        // load-use: stall, bubble, WB forward
        vecs[15] = mk(1, 2, 0, 8, 1, 1, 0, 2'd0, 2'd0, 0, 0);
        vecs[16] = mk(1, 8, 1, 9, 1, 0, 0, 2'd0, 2'd0, 1, 0);
        vecs[17] = mk(1, 8, 1, 9, 1, 0, 0, 2'd0, 2'd0, 0, 1);
        vecs[18] = nop(2'd1, 2'd0, 1);
        // flush collides with load-use: no stall, bubble in EX
        vecs[19] = mk(1, 2, 0, 8, 1, 1, 0, 2'd0, 2'd0, 0, 1);
        vecs[20] = mk(1, 8, 1, 9, 1, 0, 1, 2'd0, 2'd0, 0, 1);
        vecs[21] = nop(2'd0, 2'd0, 1);
        // back-to-back loads, each stalling
        vecs[22] = mk(1, 1, 0, 13, 1, 1, 0, 2'd0, 2'd0, 0, 1);
        vecs[23] = mk(1, 13, 0, 14, 1, 1, 0, 2'd0, 2'd0, 1, 1);
        vecs[24] = mk(1, 13, 0, 14, 1, 1, 0, 2'd0, 2'd0, 0, 2);
        vecs[25] = mk(1, 14, 13, 15, 1, 0, 0, 2'd1, 2'd0, 1, 2);
        vecs[26] = mk(1, 14, 13, 15, 1, 0, 0, 2'd0, 2'd0, 0, 3);
        vecs[27] = nop(2'd1, 2'd0, 3);
        // load to x0 never stalls or forwards
        vecs[28] = mk(1, 1, 0, 0, 1, 1, 0, 2'd0, 2'd0, 0, 3);
        vecs[29] = mk(1, 0, 1, 9, 1, 0, 0, 2'd0, 2'd0, 0, 3);
        vecs[30] = nop(2'd0, 2'd0, 3);
        // load-use through rs2
        vecs[31] = mk(1, 1, 0, 16, 1, 1, 0, 2'd0, 2'd0, 0, 3);
        vecs[32] = mk(1, 1, 16, 17, 1, 0, 0, 2'd0, 2'd0, 1, 3);
        vecs[33] = mk(1, 1, 16, 17, 1, 0, 0, 2'd0, 2'd0, 0, 4);
        vecs[34] = nop(2'd0, 2'd1, 4);

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            drive($urandom_range(1), 5'($urandom), 5'($urandom), 5'($urandom),
                  $urandom_range(1), $urandom_range(1), $urandom_range(1));
            @(negedge clk);
            check($sformatf("reset%0d fwd_a", i), 16'(fwd_a), 16'd0);
            check($sformatf("reset%0d fwd_b", i), 16'(fwd_b), 16'd0);
            check($sformatf("reset%0d stall", i), 16'(stall), 16'd0);
            check($sformatf("reset%0d cnt", i), stall_cnt, 16'd0);
            check($sformatf("reset%0d sat_cnt", i), 16'(sat_cnt), 16'd0);
        end

        for (int i = 0; i < 35; i++) begin
            @(posedge clk); #1;
            rst = 1'b1;
            drive(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                  vecs[i].rw, vecs[i].mr, vecs[i].fl);
            @(negedge clk);
            check($sformatf("v%0d fwd_a", i), 16'(fwd_a), 16'(vecs[i].a));
            check($sformatf("v%0d fwd_b", i), 16'(fwd_b), 16'(vecs[i].b));
            check($sformatf("v%0d stall", i), 16'(stall), 16'(vecs[i].st));
            check($sformatf("v%0d cnt", i), stall_cnt, vecs[i].cnt);
        end

        // four stalls seen so far: 2-bit counter pinned at 3
        check("sat_cnt_hold", 16'(sat_cnt), 16'd3);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("sat_cnt_main", stall_cnt, 16'd5 - 16'd1);
        check("sat_cnt_hold2", 16'(sat_cnt), 16'd3);

        // reset asserted in the middle of a load-use stall
        @(posedge clk); #1;
        drive(1, 2, 0, 8, 1, 1, 0);
        @(negedge clk);
        check("mid_rst lw stall", 16'(stall), 16'd0);
        @(posedge clk); #1;
        drive(1, 8, 1, 9, 1, 0, 0);
        @(negedge clk);
        check("mid_rst hazard stall", 16'(stall), 16'd1);
        check("mid_rst hazard cnt", stall_cnt, 16'd4);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst after stall", 16'(stall), 16'd0);
        check("mid_rst after cnt", stall_cnt, 16'd0);
        check("mid_rst after sat_cnt", 16'(sat_cnt), 16'd0);
        check("mid_rst after fwd_a", 16'(fwd_a), 16'd0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("mid_rst consumer fwd_a", 16'(fwd_a), 16'd0);
        check("mid_rst consumer fwd_b", 16'(fwd_b), 16'd0);
        check("mid_rst consumer cnt", stall_cnt, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
